// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment display path.
// Imported by the display arbiter and its round-robin picker.
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DWELL,
        HOLD
    } ssd_arb_state_t;

    localparam int SSD_DIGITS = 4;
    localparam int SSD_DATA_W = 4 * SSD_DIGITS;

    localparam logic [SSD_DATA_W-1:0] SSD_IDLE_PATTERN = 16'h0000;

endpackage

// File: rtl/ssd_rr_pick.sv
// Combinational round-robin picker: first set mask bit after ptr, wrapping.
// Shared by the arbiters that time-multiplex a single resource.
module ssd_rr_pick #(
    parameter int N_REQ = 3,
    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] mask,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] onehot,
    output logic             valid
);

    logic [PW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        onehot  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = PW'((int'(ptr) + i) % N_REQ);
            if (!w_found && mask[w_idx]) begin
                onehot[w_idx] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

    assign valid = |mask;

endmodule

// File: rtl/ssd_display_arbiter.sv
// Round-robin owner of the 4-digit display with a minimum dwell per grant.
// Feeds ssd_ctrl the granted hex value; blank_o gates the anodes.
module ssd_display_arbiter
    import ssd_pkg::*;
#(
    parameter int                    N_REQ        = 3,
    parameter int                    DWELL_CYCLES = 50_000_000,
    parameter logic [SSD_DATA_W-1:0] IDLE_PATTERN = SSD_IDLE_PATTERN
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [SSD_DATA_W*N_REQ-1:0] data_i,
    output logic [N_REQ-1:0]            grant_o,
    output logic [SSD_DATA_W-1:0]       number_o,
    output logic                        blank_o
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(DWELL_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL_CYCLES - 1);

    ssd_arb_state_t        r_state;
    logic [N_REQ-1:0]      r_grant;
    logic [SSD_DATA_W-1:0] r_number;
    logic                  r_blank;
    logic [CW-1:0]         r_cnt;
    logic [PW-1:0]         r_ptr;

    logic [N_REQ-1:0]      w_mask;
    logic [N_REQ-1:0]      w_win;
    logic                  w_valid;
    logic [PW-1:0]         w_win_idx;
    logic [SSD_DATA_W-1:0] w_win_data;
    logic [SSD_DATA_W-1:0] w_gr_data;
    logic                  w_gr_hi;

    // In IDLE the grant is zero, so this is plain req_i there.
    assign w_mask  = req_i & ~r_grant;
    assign w_gr_hi = |(req_i & r_grant);

    ssd_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .mask   (w_mask),
        .ptr    (r_ptr),
        .onehot (w_win),
        .valid  (w_valid)
    );

    always_comb begin
        w_win_idx  = '0;
        w_win_data = '0;
        w_gr_data  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_win[k]) begin
                w_win_idx  = PW'(k);
                w_win_data = data_i[SSD_DATA_W*k +: SSD_DATA_W];
            end
            if (r_grant[k]) begin
                w_gr_data = data_i[SSD_DATA_W*k +: SSD_DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_number <= IDLE_PATTERN;
            r_blank  <= 1'b1;
            r_cnt    <= '0;
            r_ptr    <= PW'(N_REQ - 1);
        end else begin
            // A pending competitor always wins over idling or holding.
            if (w_valid && (r_state == IDLE || r_cnt == '0)) begin
                r_state  <= DWELL;
                r_grant  <= w_win;
                r_number <= w_win_data;
                r_blank  <= 1'b0;
                r_cnt    <= CNT_LOAD;
                r_ptr    <= w_win_idx;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_grant  <= '0;
                        r_number <= IDLE_PATTERN;
                        r_blank  <= 1'b1;
                    end
                    DWELL, HOLD: begin
                        if (r_state == DWELL && r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                            if (w_gr_hi) r_number <= w_gr_data;
                        end else if (w_gr_hi) begin
                            r_state  <= HOLD;
                            r_number <= w_gr_data;
                        end else begin
                            r_state  <= IDLE;
                            r_grant  <= '0;
                            r_number <= IDLE_PATTERN;
                            r_blank  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_grant  <= '0;
                        r_number <= IDLE_PATTERN;
                        r_blank  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign grant_o  = r_grant;
    assign number_o = r_number;
    assign blank_o  = r_blank;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Directed bench for ssd_display_arbiter, N_REQ=3, DWELL_CYCLES=4.
// Expected values are hand-derived from the dwell/round-robin rules.
module tb_ssd_display_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [47:0] data;
    logic [2:0]  grant;
    logic [15:0] number;
    logic        blank;

    int n_chk = 0;
    int n_pass = 0;

    ssd_display_arbiter #(
        .N_REQ        (3),
        .DWELL_CYCLES (4),
        .IDLE_PATTERN (16'h0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req),
        .data_i   (data),
        .grant_o  (grant),
        .number_o (number),
        .blank_o  (blank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] g,
                           input logic [15:0] n, input logic b);
        chk({tag, ".grant"}, {13'd0, grant}, {13'd0, g});
        chk({tag, ".number"}, number, n);
        chk({tag, ".blank"}, {15'd0, blank}, {15'd0, b});
    endtask

    logic [2:0]  g_exp;
    logic [15:0] n_exp;

    initial begin
        req   = '0;
        data  = '0;
        rst_n = 1'b0;
        #12;
        chk_out("rst", 3'b000, 16'h0000, 1'b1);

        // Single requester: grant, live tracking, indefinite hold
        do_reset();
        data[31:16] = 16'h1234;
        req = 3'b010;
        tick();
        chk_out("single", 3'b010, 16'h1234, 1'b0);
        data[31:16] = 16'h1235;
        tick();
        chk("single.track", number, 16'h1235);
        repeat (6) tick();
        chk_out("single.hold", 3'b010, 16'h1235, 1'b0);
        req = 3'b000;
        tick();
        chk_out("single.idle", 3'b000, 16'h0000, 1'b1);

        // Rotation with all three requesting
        do_reset();
        data = {16'hC2C2, 16'hB1B1, 16'hA0A0};
        req  = 3'b111;
        for (int c = 0; c < 16; c++) begin
            tick();
            g_exp = 3'b001 << ((c / 4) % 3);
            n_exp = (g_exp == 3'b001) ? 16'hA0A0 :
                    (g_exp == 3'b010) ? 16'hB1B1 : 16'hC2C2;
            chk($sformatf("rot%0d.grant", c), {13'd0, grant}, {13'd0, g_exp});
            chk($sformatf("rot%0d.number", c), number, n_exp);
        end

        // Asynchronous reset mid-dwell, then restart at requester 0
        tick();
        rst_n = 1'b0;
        #1;
        chk_out("rst.mid", 3'b000, 16'h0000, 1'b1);
        #3;
        rst_n = 1'b1;
        tick();
        chk_out("rst.restart", 3'b001, 16'hA0A0, 1'b0);

        // Early drop: one-cycle pulse keeps grant for full dwell, frozen
        do_reset();
        data[15:0] = 16'hABCD;
        req = 3'b001;
        tick();
        chk_out("drop.grant", 3'b001, 16'hABCD, 1'b0);
        req = 3'b000;
        data[15:0] = 16'h1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out($sformatf("drop.frz%0d", c), 3'b001, 16'hABCD, 1'b0);
        end
        tick();
        chk_out("drop.idle", 3'b000, 16'h0000, 1'b1);

        // Preemption from HOLD, then requester 0 regains after dwell
        do_reset();
        data = {16'hC2C2, 16'hB1B1, 16'hABCD};
        req  = 3'b001;
        repeat (6) tick();
        chk_out("pre.hold", 3'b001, 16'hABCD, 1'b0);
        req = 3'b101;
        tick();
        chk_out("pre.sw", 3'b100, 16'hC2C2, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out($sformatf("pre.dw%0d", c), 3'b100, 16'hC2C2, 1'b0);
        end
        tick();
        chk_out("pre.back", 3'b001, 16'hABCD, 1'b0);

        // Drop and new request together at dwell end: no blank cycle
        do_reset();
        data = {16'hC2C2, 16'hB1B1, 16'hA0A0};
        req  = 3'b001;
        repeat (4) tick();
        chk_out("sim.last", 3'b001, 16'hA0A0, 1'b0);
        req = 3'b010;
        tick();
        chk_out("sim.sw", 3'b010, 16'hB1B1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
